// File: rtl/chroni_vram_port_if.sv
// Signal bundle between chroni_vram_port, its two requesters (chroni video fetch,
// CPU bridge) and the VRAM macro. slave = responder view, master = environment view.
interface chroni_vram_port_if;
  logic [12:0] vid_addr;
  logic [7:0]  vid_addr_page;
  logic        vid_rd_req;
  logic [7:0]  vid_data_out;
  logic        vid_rd_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [20:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  vid_addr, vid_addr_page, vid_rd_req,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vid_data_out, vid_rd_ack,
    output cpu_rdata, cpu_ack,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output vid_addr, vid_addr_page, vid_rd_req,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vid_data_out, vid_rd_ack,
    input  cpu_rdata, cpu_ack,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/chroni_vram_port.sv
// VRAM responder: arbitrates chroni video fetches against CPU accesses and runs
// single-byte transactions on a fixed-latency synchronous VRAM.
module chroni_vram_port #(
  parameter int MEM_LATENCY      = 2,
  parameter int CPU_STARVE_LIMIT = 4
) (
  input logic               sys_clk,
  input logic               reset_n,
  chroni_vram_port_if.slave bus
);
  // state   | meaning
  // IDLE    | sample requests and arbitrate
  // RD_WAIT | mem_re issued, lat_cnt counting down to read data
  // WR      | mem_we issued, one settle cycle before the ack
  // ACK     | owner's ack high for one cycle, then turnaround to IDLE
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, ACK} state_t;

  localparam logic [2:0] RD_LAT     = 3'(MEM_LATENCY);
  localparam logic [3:0] STARVE_LIM = 4'(CPU_STARVE_LIMIT);

  state_t     state;
  logic [2:0] starve_cnt;
  logic [2:0] lat_cnt;
  logic       owner_cpu;
  logic       vid_win;

  assign vid_win = bus.vid_rd_req &&
                   (!bus.cpu_req || ({1'b0, starve_cnt} < STARVE_LIM));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      lat_cnt          <= '0;
      owner_cpu        <= 1'b0;
      bus.vid_data_out <= '0;
      bus.vid_rd_ack   <= 1'b0;
      bus.cpu_rdata    <= '0;
      bus.cpu_ack      <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_re       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_wdata    <= '0;
    end else begin
      bus.mem_re     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.vid_rd_ack <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (vid_win) begin
            owner_cpu    <= 1'b0;
            bus.mem_addr <= {bus.vid_addr_page, bus.vid_addr};
            bus.mem_re   <= 1'b1;
            lat_cnt      <= RD_LAT;
            state        <= RD_WAIT;
            if (!bus.cpu_req)
              starve_cnt <= '0;
            else if (starve_cnt != 3'd7)
              starve_cnt <= starve_cnt + 3'd1;
          end else if (bus.cpu_req) begin
            owner_cpu    <= 1'b1;
            starve_cnt   <= '0;
            bus.mem_addr <= bus.cpu_addr;
            if (bus.cpu_we) begin
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= bus.cpu_wdata;
              // one extra settle cycle puts the write ack two cycles after the strobe
              lat_cnt       <= 3'd1;
              state         <= WR;
            end else begin
              bus.mem_re <= 1'b1;
              lat_cnt    <= RD_LAT;
              state      <= RD_WAIT;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 3'd0) begin
            if (owner_cpu) begin
              bus.cpu_rdata <= bus.mem_rdata;
              bus.cpu_ack   <= 1'b1;
            end else begin
              bus.vid_data_out <= bus.mem_rdata;
              bus.vid_rd_ack   <= 1'b1;
            end
            state <= ACK;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        WR: begin
          if (lat_cnt == 3'd0) begin
            bus.cpu_ack <= 1'b1;
            state       <= ACK;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chroni_vram_port.sv
// Bench for chroni_vram_port: three instances (latency 2, 1, 7) on VRAM models,
// expected strobes and acks queued at stimulus time and matched when they appear.
module tb_chroni_vram_port;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_assert;
  int   n_fail;

  typedef struct {
    logic [20:0] addr;
    logic        we;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t sq [3][$];
  exp_t vq [3][$];
  exp_t cq [3][$];

  chroni_vram_port_if bus [3] ();

  virtual chroni_vram_port_if v0;
  virtual chroni_vram_port_if v1;
  virtual chroni_vram_port_if v2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] vram_init(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h46;
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, expv);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_vram
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [7:0] pipe [8];
    logic [7:0] wr_mem [logic [20:0]];

    chroni_vram_port #(.MEM_LATENCY(LAT), .CPU_STARVE_LIMIT(4)) u_dut (
      .sys_clk (clk),
      .reset_n (rst_n),
      .bus     (bus[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (bus[g].mem_re || bus[g].mem_we) begin
        if (sq[g].size() == 0) begin
          chk("strobe_unexpected", g, 32'({bus[g].mem_re, bus[g].mem_we}), 32'd0);
        end else begin
          e = sq[g].pop_front();
          chk("strobe_kind", g, 32'({bus[g].mem_re, bus[g].mem_we}), 32'({~e.we, e.we}));
          chk("strobe_addr", g, 32'(bus[g].mem_addr), 32'(e.addr));
          if (e.we) chk("strobe_wdata", g, 32'(bus[g].mem_wdata), 32'(e.data));
          chk("strobe_cycle", g, 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus[g].vid_rd_ack) begin
        chk("ack_exclusive", g, 32'(bus[g].cpu_ack), 32'd0);
        if (vq[g].size() == 0) begin
          chk("vid_ack_unexpected", g, 32'(bus[g].vid_rd_ack), 32'd0);
        end else begin
          e = vq[g].pop_front();
          chk("vid_data", g, 32'(bus[g].vid_data_out), 32'(e.data));
          chk("vid_ack_cycle", g, 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus[g].cpu_ack) begin
        if (cq[g].size() == 0) begin
          chk("cpu_ack_unexpected", g, 32'(bus[g].cpu_ack), 32'd0);
        end else begin
          e = cq[g].pop_front();
          if (!e.we) chk("cpu_rdata", g, 32'(bus[g].cpu_rdata), 32'(e.data));
          chk("cpu_ack_cycle", g, 32'(cyc), 32'(e.cyc));
        end
      end

      for (int k = 7; k > 0; k--) pipe[k] = pipe[k-1];
      if (bus[g].mem_re)
        pipe[0] = wr_mem.exists(bus[g].mem_addr) ? wr_mem[bus[g].mem_addr]
                                                 : vram_init(bus[g].mem_addr);
      else
        pipe[0] = 8'hEE;
      if (bus[g].mem_we) wr_mem[bus[g].mem_addr] = bus[g].mem_wdata;
      bus[g].mem_rdata = pipe[LAT];
    end
  end

  task automatic clear_inputs(virtual chroni_vram_port_if v);
    v.vid_addr      = '0;
    v.vid_addr_page = '0;
    v.vid_rd_req    = 1'b0;
    v.cpu_req       = 1'b0;
    v.cpu_we        = 1'b0;
    v.cpu_addr      = '0;
    v.cpu_wdata     = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int pending(input int inst);
    return sq[inst].size() + vq[inst].size() + cq[inst].size();
  endfunction

  task automatic wait_done(input int inst, input int budget);
    int n = 0;
    while (pending(inst) != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk("done_timeout", inst, 32'(pending(inst)), 32'd0);
  endtask

  // raises vid_rd_req in the current (IDLE) cycle and queues strobe and ack
  task automatic vid_issue(virtual chroni_vram_port_if v, input int inst, input int lat,
                           input logic [7:0] page, input logic [12:0] off,
                           input logic [7:0] exp_data);
    logic [20:0] a;
    a = {page, off};
    v.vid_addr_page = page;
    v.vid_addr      = off;
    v.vid_rd_req    = 1'b1;
    sq[inst].push_back('{a, 1'b0, 8'h00, cyc + 1});
    vq[inst].push_back('{a, 1'b0, exp_data, cyc + 2 + lat});
  endtask

  // CPU holds cpu_req until its ack and drops it on the ack edge
  task automatic cpu_op(virtual chroni_vram_port_if v, input int inst, input int lat,
                        input logic we, input logic [20:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd);
    int n = 0;
    v.cpu_req   = 1'b1;
    v.cpu_we    = we;
    v.cpu_addr  = a;
    v.cpu_wdata = wd;
    sq[inst].push_back('{a, we, wd, cyc + 1});
    cq[inst].push_back('{a, we, exp_rd, we ? cyc + 3 : cyc + 2 + lat});
    while (cq[inst].size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    v.cpu_req = 1'b0;
    chk("cpu_timeout", inst, 32'(cq[inst].size()), 32'd0);
    step(1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] va;
    int          n0;
    n_assert = 0;
    n_fail   = 0;
    v0 = bus[0];
    v1 = bus[1];
    v2 = bus[2];
    rst_n = 1'b0;
    clear_inputs(v0);
    clear_inputs(v1);
    clear_inputs(v2);
    step(2);

    chk("rst_vid_data", 0, 32'(v0.vid_data_out), 32'd0);
    chk("rst_vid_ack",  0, 32'(v0.vid_rd_ack),   32'd0);
    chk("rst_cpu_data", 0, 32'(v0.cpu_rdata),    32'd0);
    chk("rst_cpu_ack",  0, 32'(v0.cpu_ack),      32'd0);
    chk("rst_mem_addr", 0, 32'(v0.mem_addr),     32'd0);
    chk("rst_mem_re",   0, 32'(v0.mem_re),       32'd0);
    chk("rst_mem_we",   0, 32'(v0.mem_we),       32'd0);
    chk("rst_mem_wdata",0, 32'(v0.mem_wdata),    32'd0);
    rst_n = 1'b1;
    step(1);

    // basic video read, VRAM holds 0x41 at 0x00403
    vid_issue(v0, 0, 2, 8'h00, 13'h0403, 8'h41);
    step(1);
    v0.vid_rd_req = 1'b0;
    wait_done(0, 20);
    chk("vid_hold", 0, 32'(v0.vid_data_out), 32'h41);
    chk("addr_hold", 0, 32'(v0.mem_addr), 32'h00403);

    // one-cycle pulse; address inputs scrambled right after grant
    vid_issue(v0, 0, 2, 8'h12, 13'h1FFF, vram_init(21'h25FFF));
    step(1);
    v0.vid_rd_req    = 1'b0;
    v0.vid_addr      = 13'h0000;
    v0.vid_addr_page = 8'h34;
    wait_done(0, 20);
    chk("pulse_addr_hold", 0, 32'(v0.mem_addr), 32'h25FFF);

    // CPU write then read back
    cpu_op(v0, 0, 2, 1'b1, 21'h1ABCD, 8'h5A, 8'h00);
    cpu_op(v0, 0, 2, 1'b0, 21'h1ABCD, 8'h00, 8'h5A);
    chk("cpu_rdata_hold", 0, 32'(v0.cpu_rdata), 32'h5A);

    // video level-held plus CPU waiting: four video grants, CPU, then video
    va = {8'h01, 13'h0010};
    n0 = cyc;
    v0.vid_addr_page = 8'h01;
    v0.vid_addr      = 13'h0010;
    v0.vid_rd_req    = 1'b1;
    v0.cpu_req       = 1'b1;
    v0.cpu_we        = 1'b0;
    v0.cpu_addr      = 21'h00777;
    for (int k = 0; k < 4; k++) begin
      sq[0].push_back('{va, 1'b0, 8'h00, n0 + 1 + 5 * k});
      vq[0].push_back('{va, 1'b0, vram_init(va), n0 + 4 + 5 * k});
    end
    sq[0].push_back('{21'h00777, 1'b0, 8'h00, n0 + 21});
    cq[0].push_back('{21'h00777, 1'b0, vram_init(21'h00777), n0 + 24});
    sq[0].push_back('{va, 1'b0, 8'h00, n0 + 26});
    vq[0].push_back('{va, 1'b0, vram_init(va), n0 + 29});
    step(24);
    @(negedge clk);
    #1;
    v0.cpu_req = 1'b0;
    step(2);
    v0.vid_rd_req = 1'b0;
    wait_done(0, 20);

    // reset while in RD_WAIT abandons the read
    vid_issue(v0, 0, 2, 8'h03, 13'h0055, vram_init(21'h06055));
    step(1);
    v0.vid_rd_req = 1'b0;
    step(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_addr", 0, 32'(v0.mem_addr),     32'd0);
    chk("midrst_vid_data", 0, 32'(v0.vid_data_out), 32'd0);
    chk("midrst_cpu_data", 0, 32'(v0.cpu_rdata),    32'd0);
    chk("midrst_acks",     0, 32'({v0.vid_rd_ack, v0.cpu_ack}), 32'd0);
    chk("midrst_strobes",  0, 32'({v0.mem_re, v0.mem_we}),      32'd0);
    vq[0].delete();
    sq[0].delete();
    step(2);
    rst_n = 1'b1;
    step(8);
    chk("no_capture_after_rst", 0, 32'(v0.vid_data_out), 32'd0);

    vid_issue(v0, 0, 2, 8'h0F, 13'h0ABC, vram_init({8'h0F, 13'h0ABC}));
    step(1);
    v0.vid_rd_req = 1'b0;
    wait_done(0, 20);

    // latency 1 instance
    vid_issue(v1, 1, 1, 8'h02, 13'h0100, vram_init({8'h02, 13'h0100}));
    step(1);
    v1.vid_rd_req = 1'b0;
    wait_done(1, 20);
    cpu_op(v1, 1, 1, 1'b0, 21'h0AA55, 8'h00, vram_init(21'h0AA55));

    // latency 7 instance
    cpu_op(v2, 2, 7, 1'b0, 21'h1F00F, 8'h00, vram_init(21'h1F00F));
    vid_issue(v2, 2, 7, 8'h7F, 13'h1FFE, vram_init({8'h7F, 13'h1FFE}));
    step(1);
    v2.vid_rd_req = 1'b0;
    wait_done(2, 30);
    cpu_op(v2, 2, 7, 1'b1, 21'h00042, 8'hC3, 8'h00);
    cpu_op(v2, 2, 7, 1'b0, 21'h00042, 8'h00, 8'hC3);

    step(4);
    for (int i = 0; i < 3; i++) chk("queues_empty", i, 32'(pending(i)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/chroni_vram_port.md
# chroni_vram_port

Memory-side responder for the chroni video fetch port and the CPU VRAM port. It arbitrates between the two requesters and runs single-byte transactions against a synchronous VRAM with fixed read latency. Read data is returned with a one-cycle acknowledge pulse. The block sits between chroni's `addr_out`/`addr_out_page`/`rd_req`/`rd_ack`/`data_in` pins, the CPU bus bridge and the VRAM macro.

## Interface
Parameters
- `MEM_LATENCY`, default 2: VRAM read latency in cycles, legal range 1..7.
- `CPU_STARVE_LIMIT`, default 4: number of consecutive video grants allowed while a CPU request waits.

Ports
- `sys_clk` in 1: the only clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `vid_addr` in 13: video byte address within the page.
- `vid_addr_page` in 8: video page.
- `vid_rd_req` in 1: video read request (pulse or level).
- `vid_data_out` out 8: read data, valid in the `vid_rd_ack` cycle.
- `vid_rd_ack` out 1: one-cycle acknowledge.
- `cpu_req` in 1: CPU request, level held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 21: `{page, offset}`.
- `cpu_wdata` in 8: write data.
- `cpu_rdata` out 8: read data, valid in the `cpu_ack` cycle.
- `cpu_ack` out 1: one-cycle acknowledge.
- `mem_addr` out 21: VRAM address.
- `mem_re` out 1: VRAM read strobe.
- `mem_we` out 1: VRAM write strobe.
- `mem_wdata` out 8: VRAM write data.
- `mem_rdata` in 8: VRAM read data, valid `MEM_LATENCY` cycles after the `mem_re` cycle.

## Operation
- States:
  - IDLE
  - RD_WAIT
  - WR
  - ACK
- Only IDLE samples requests. This gives one turnaround cycle after every ACK, so a requester that updates its request on the ack edge is seen correctly.
- Arbitration in IDLE:
  - Video wins if `vid_rd_req` and (`!cpu_req` or `starve_cnt < CPU_STARVE_LIMIT`).
  - Otherwise CPU wins if `cpu_req`.
  - `starve_cnt` (3 bits, saturating) increments on each video grant made while `cpu_req` is high.
  - `starve_cnt` clears on a CPU grant or whenever `cpu_req` is low in IDLE.
- On grant:
  - The address is latched as `{vid_addr_page, vid_addr}` or `cpu_addr`.
  - The owner flag, `cpu_we` and `cpu_wdata` are latched.
  - Later changes on request inputs are ignored until the next IDLE.
- Read: next cycle `mem_re`=1 for exactly one cycle, then RD_WAIT. `lat_cnt` loads `MEM_LATENCY` and counts down. At 0, `mem_rdata` is captured into the owner's data register and the state moves to ACK.
- Write (CPU only): next cycle `mem_we`=1 for one cycle with `mem_addr`/`mem_wdata` (the WR state), then ACK.
- ACK: the owner's ack is high for exactly one cycle, then IDLE.
- A video request that deasserts after being granted still completes and is acked. chroni's text fetch pulses `rd_req` for one cycle only.
- `vid_data_out`/`cpu_rdata` hold their last value between acks.
- `mem_addr` holds its last value when no strobe is active.

## Timing
- Reset (async assert, sync release) sets:
  - all outputs to 0;
  - state to IDLE;
  - `starve_cnt` and `lat_cnt` to 0.
- Reset mid-transaction abandons the transaction: no ack, no strobe.
- Request sampled in IDLE in cycle N:
  - Memory strobe in N+1.
  - Read ack in N+2+`MEM_LATENCY` (N+4 at default).
  - Write ack in N+3.
- Back-to-back reads: next IDLE sample is at ack+1. Video throughput is one byte per `MEM_LATENCY`+3 cycles.
- `mem_re` and `mem_we` are never high together. Both are registered outputs.
- `vid_rd_ack` and `cpu_ack` are never high together.
- Simultaneous `vid_rd_req` and `cpu_req` with `starve_cnt` < limit: video granted.

## Test plan
- Reset, video read at page 0x00 offset 0x0403, VRAM returns 0x41 → `mem_re` in N+1 with `mem_addr`=0x00403; `vid_rd_ack` one cycle at N+4; `vid_data_out`=0x41.
- One-cycle `vid_rd_req` pulse at page 0x12 offset 0x1FFF → `mem_addr`=0x25FFF; ack still issued. `vid_addr` changed after grant has no effect.
- CPU write 0x5A to 0x1ABCD then CPU read of the same address → `mem_we` one cycle with `mem_wdata`=0x5A; `cpu_ack` at N+3; read returns `cpu_rdata`=0x5A.
- Video `rd_req` held high continuously plus `cpu_req` high → exactly 4 video grants, then a CPU grant, then video resumes.
- Assert `reset_n`=0 during RD_WAIT → all outputs 0 immediately, no ack after release; next request served normally.
- Sweep `MEM_LATENCY` = 1 and 7 → read ack at N+3 and N+9 respectively; data correct.
